apb_mem_slave: RTL
==================

# apb_mem_slave

Parametrised APB slave with on-chip word memory. It is the next generation of the team's single-purpose APB memory slave: configurable data width, depth and wait states; full SETUP/ACCESS protocol tracking; PSLVERR on out-of-range addresses; optional byte-strobe writes. It sits behind the APB bridge/decoder as a leaf peripheral, one PSEL per instance.

## Interface
- DATA_W, 32: data bus width; multiple of 8, 8..64.
- ADDR_W, 32: PADDR width.
- DEPTH, 16: number of DATA_W-bit words; 2..1024.
- WAIT_STATES, 0: extra ACCESS cycles with PREADY low before completion; 0..15.
- INIT_STEP, 5: word i powers up holding i*INIT_STEP, truncated to DATA_W. This is a time-zero initial value, not a reset value.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  reset; synchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte write strobes. Present only with APB_MEM_PSTRB_EN.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer completes this cycle, registered.
- PSLVERR  out  1  error response, registered; meaningful only while PREADY=1.

## Operation
- Word index: idx = PADDR[ADDR_LSB +: IDX_W], with ADDR_LSB = log2(DATA_W/8) and IDX_W = clog2(DEPTH).
  - PADDR bits below ADDR_LSB are ignored.
  - The address is out of range when any PADDR bit above ADDR_LSB+IDX_W-1 is set, or when idx >= DEPTH.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - A setup phase (PSEL=1, PENABLE=0) moves to ACCESS and loads the wait counter with WAIT_STATES.
  - PREADY <= (WAIT_STATES==0).
  - PSLVERR <= out_of_range.
  - PRDATA <= (read && in range) ? mem[idx] : 0.
  - PADDR, PWRITE, PWDATA and PSTRB are captured.
- ACCESS with counter > 0: the counter decrements; PREADY <= (counter==1).
- ACCESS with PREADY=1, PSEL=1, PENABLE=1: the transfer completes.
  - An in-range write commits the captured data at this edge.
  - An out-of-range write changes no memory.
  - PREADY, PSLVERR and PRDATA go to 0; the FSM returns to IDLE.
- ACCESS with PSEL=0 (master abort): the FSM returns to IDLE, all outputs go to 0, no write.
- PSEL=1 with PENABLE=1 while in IDLE is a protocol error. It is ignored: the FSM stays in IDLE and PREADY stays 0.
- Back-to-back transfers always pass through IDLE/SETUP. A read immediately after a write to the same word returns the new data.

## Timing
- Reset (PRESETn=0 at an edge): FSM = IDLE, counter = 0, PREADY = 0, PSLVERR = 0, PRDATA = 0. Memory contents are preserved.
- Reset during ACCESS cancels the transfer with no write.
- Transfer length is 2 + WAIT_STATES cycles: SETUP plus ACCESS cycles. With WAIT_STATES=0, PREADY is high in the first ACCESS cycle.
- PRDATA and PSLVERR are stable from the first ACCESS cycle through completion.
- Address and data are sampled only in the SETUP cycle. Changes during ACCESS are ignored.

## Configuration
- APB_MEM_PSTRB_EN defined:
  - The PSTRB port exists.
  - Writes update only the bytes whose strobe bit is 1.
  - PSTRB=0 on an in-range write completes OKAY and changes nothing.
- APB_MEM_PSTRB_EN undefined: no PSTRB port; every write updates all bytes.
- Reads ignore PSTRB in both builds.

## Structure
- Package apb_mem_pkg holds:
  - the FSM state typedef (ST_IDLE, ST_ACCESS);
  - the wait-counter width constant (4);
  - the strobe-width and ADDR_LSB helper functions.
- Sub-module apb_mem_array provides the storage: DEPTH x DATA_W, one synchronous write port with byte enables, and an asynchronous read port sampled by the FSM. It also owns the INIT_STEP initial contents.
- Top level holds the FSM, the wait counter, range checking and output registers.

## Test plan
- Reset, then read word 3 with defaults → PRDATA=15 and PREADY=1 in cycle 2, PSLVERR=0. Read word 10 → PRDATA=50.
- Write 0xDEADBEEF to PADDR=0x08, then read PADDR=0x08 → 0xDEADBEEF. PADDR=0x09 and 0x0B also return 0xDEADBEEF (low bits ignored).
- WAIT_STATES=3, read PADDR=0x04 → PREADY low for 3 ACCESS cycles, high in the 4th, PRDATA=5 held throughout.
- PADDR=0x40 (idx 16, DEPTH 16), write 0x1234 → PSLVERR=1 with PREADY=1, memory unchanged. A read of the same address returns PRDATA=0 and PSLVERR=1.
- With APB_MEM_PSTRB_EN: word 2 = 0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 → readback 0x11BB33DD.
- WAIT_STATES=2, drop PSEL or assert PRESETn=0 mid-write to word 1 → PREADY stays 0, FSM returns to IDLE, word 1 still reads 5.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB word-memory slave.
// Optional byte strobes are enabled with the APB_MEM_PSTRB_EN macro.
package apb_mem_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    localparam int CNT_W = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage: byte-enabled synchronous write, asynchronous read.
// Power-up contents are word i = i*INIT_STEP; there is no reset of the array.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int INIT_STEP = 5,
    parameter int IDX_W     = 4,
    parameter int BE_W      = strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    function automatic logic [DEPTH*DATA_W-1:0] init_image();
        logic [DEPTH*DATA_W-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i*DATA_W +: DATA_W] = DATA_W'(i * INIT_STEP);
        end
        return img;
    endfunction

    logic [DEPTH-1:0][DATA_W-1:0] mem = init_image();

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Guard keeps non-power-of-two depths from reading past the array.
    assign rdata = (32'(ridx) < DEPTH) ? mem[ridx] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// APB leaf slave backed by apb_mem_array: wait states, range checking, PSLVERR.
// Define APB_MEM_PSTRB_EN to add the PSTRB port and byte-masked writes.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int INIT_STEP   = 5
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_W-1:0]         PADDR,
    input  logic [DATA_W-1:0]         PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [strb_w(DATA_W)-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]         PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
);

    localparam int STRB_W   = strb_w(DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                pready_nx, pslverr_nx;
    logic [DATA_W-1:0]   prdata_nx;
    logic                load, mem_we;

    logic [IDX_W-1:0]    idx, cap_idx;
    logic                oor, cap_oor, cap_write;
    logic [DATA_W-1:0]   cap_wdata, rd_data;
    logic [STRB_W-1:0]   cap_strb, be;

    assign idx = PADDR[ADDR_LSB +: IDX_W];
    assign oor = ((PADDR >> (ADDR_LSB + IDX_W)) != '0) || (32'(idx) >= DEPTH);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pready_nx  = PREADY;
        pslverr_nx = PSLVERR;
        prdata_nx  = PRDATA;
        load       = 1'b0;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                pready_nx  = 1'b0;
                pslverr_nx = 1'b0;
                prdata_nx  = '0;
                if (PSEL && !PENABLE) begin
                    state_nx   = ST_ACCESS;
                    cnt_nx     = CNT_W'(WAIT_STATES);
                    pready_nx  = (WAIT_STATES == 0);
                    pslverr_nx = oor;
                    prdata_nx  = (!PWRITE && !oor) ? rd_data : '0;
                    load       = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_nx   = ST_IDLE;
                    cnt_nx     = '0;
                    pready_nx  = 1'b0;
                    pslverr_nx = 1'b0;
                    prdata_nx  = '0;
                end else if (cnt != '0) begin
                    cnt_nx    = cnt - CNT_W'(1);
                    pready_nx = (cnt == CNT_W'(1));
                end else if (PREADY && PENABLE) begin
                    mem_we     = cap_write && !cap_oor;
                    state_nx   = ST_IDLE;
                    pready_nx  = 1'b0;
                    pslverr_nx = 1'b0;
                    prdata_nx  = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            PREADY  <= pready_nx;
            PSLVERR <= pslverr_nx;
            PRDATA  <= prdata_nx;
        end
    end

    // Transfer attributes are frozen in SETUP; ACCESS-phase bus changes are ignored.
    always_ff @(posedge PCLK) begin
        if (load) begin
            cap_idx   <= idx;
            cap_oor   <= oor;
            cap_write <= PWRITE;
            cap_wdata <= PWDATA;
`ifdef APB_MEM_PSTRB_EN
            cap_strb  <= PSTRB;
`else
            cap_strb  <= '1;
`endif
        end
    end

    assign be = cap_strb;

    apb_mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_STEP (INIT_STEP),
        .IDX_W     (IDX_W),
        .BE_W      (STRB_W)
    ) u_array (
        .clk   (PCLK),
        .we    (mem_we && PRESETn),
        .widx  (cap_idx),
        .wdata (cap_wdata),
        .be    (be),
        .ridx  (idx),
        .rdata (rd_data)
    );

endmodule
